pll_reset_sequencer: RTL



---
 rtl/pll_reset_sequencer_pkg.sv | 25 ++
 rtl/pll_reset_sequencer_sync_bit.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_STABLE_CYCLES       = 1024;
  localparam int unsigned DEF_SYNC_STAGES         = 2;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain; clears to 0 on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the system reset; re-sequences on timeout or loss of lock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [1:0] state
);

  localparam int unsigned MAX_CYC = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int unsigned CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  logic          w_locked_s;
  pll_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pll_rst;
  logic          r_sys_rst;
  logic          r_ready;
  logic          r_lock_lost;
  logic [7:0]    r_retry_count;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  // Sequencer FSM; each output is written with the state it belongs to so it
  // changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= PLL_RST;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_retry_count <= '0;
    end else begin
      r_lock_lost <= 1'b0;
      case (r_state)
        PLL_RST: begin
          if (r_cnt == RST_LAST) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a coincident timeout.
          if (w_locked_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state   <= PLL_RST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            if (r_retry_count != 8'hFF) r_retry_count <= r_retry_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STABLE: begin
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b1;
          end
        end
        default: begin
          r_state   <= PLL_RST;
          r_cnt     <= '0;
          r_pll_rst <= 1'b1;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry_count;
  assign state       = r_state;

endmodule
